regfile_access_ctrl: RTL and testbench

REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

---
 rtl/regfile_access_ctrl.sv | 167 ++++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: serialises operand reads and queued
// writebacks onto a single-port RF, with bypass from the writeback queue.
module regfile_access_ctrl #(
    parameter int QDEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rd_req_valid,
    output logic       rd_req_ready,
    input  logic [4:0] rd_src1,
    input  logic [4:0] rd_src2,
    output logic       rd_rsp_valid,
    input  logic       rd_rsp_ready,
    output logic [7:0] rd_data1,
    output logic [7:0] rd_data2,
    input  logic       wb_valid,
    output logic       wb_ready,
    input  logic [4:0] wb_dst,
    input  logic [7:0] wb_data,
    output logic       rf_read,
    output logic [4:0] rf_rsrc1,
    output logic [4:0] rf_rsrc2,
    output logic [4:0] rf_rdst,
    output logic [7:0] rf_in,
    input  logic [7:0] rf_out1,
    input  logic [7:0] rf_out2,
    output logic [3:0] wbq_count
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_e;

    state_e        state_q, state_d;
    logic [4:0]    src1_q, src1_d;
    logic [4:0]    src2_q, src2_d;
    logic [7:0]    data1_q, data1_d;
    logic [7:0]    data2_q, data2_d;

    logic [4:0]    qdst_q [QDEPTH];
    logic [7:0]    qdat_q [QDEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [3:0]    count_q, count_d;

    logic          not_full;
    logic          push;
    logic          pop;
    logic [PW-1:0] idx;
    logic [7:0]    byp1;
    logic [7:0]    byp2;

    assign not_full  = count_q < 4'(QDEPTH);
    assign wb_ready  = not_full;
    assign push      = wb_valid && not_full;
    assign pop       = (state_q == WRITE);
    assign count_d   = count_q + {3'b000, push} - {3'b000, pop};
    assign wbq_count = count_q;
    assign rd_data1  = data1_q;
    assign rd_data2  = data2_q;

    // Operand bypass: same-cycle writeback beats youngest queued entry beats RF.
    always_comb begin
        byp1 = rf_out1;
        byp2 = rf_out2;
        idx  = rd_ptr_q;
        for (int i = 0; i < QDEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (4'(i) < count_q) begin
                if (qdst_q[idx] == src1_q) byp1 = qdat_q[idx];
                if (qdst_q[idx] == src2_q) byp2 = qdat_q[idx];
            end
        end
        if (push && wb_dst == src1_q) byp1 = wb_data;
        if (push && wb_dst == src2_q) byp2 = wb_data;
    end

    // Next-state and RF port drive; reset masks any RF write in its cycle.
    always_comb begin
        state_d      = state_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        data1_d      = data1_q;
        data2_d      = data2_q;
        rd_req_ready = 1'b0;
        rd_rsp_valid = 1'b0;
        rf_read      = 1'b1;
        rf_rsrc1     = 5'd0;
        rf_rsrc2     = 5'd0;
        rf_rdst      = 5'd0;
        rf_in        = 8'd0;
        unique case (state_q)
            IDLE: begin
                rd_req_ready = not_full;
                if (rd_req_valid && not_full) begin
                    state_d = READ;
                    src1_d  = rd_src1;
                    src2_d  = rd_src2;
                end else if (count_q != 4'd0) begin
                    state_d = WRITE;
                end
            end
            READ: begin
                rf_rsrc1 = src1_q;
                rf_rsrc2 = src2_q;
                data1_d  = byp1;
                data2_d  = byp2;
                state_d  = RESP;
            end
            WRITE: begin
                rf_read = 1'b0;
                rf_rdst = qdst_q[rd_ptr_q];
                rf_in   = qdat_q[rd_ptr_q];
                state_d = IDLE;
            end
            RESP: begin
                rd_rsp_valid = 1'b1;
                if (rd_rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            rf_read  = 1'b1;
            rf_rsrc1 = 5'd0;
            rf_rsrc2 = 5'd0;
            rf_rdst  = 5'd0;
            rf_in    = 8'd0;
        end
    end

    // Control state, captured operands and queue pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            src1_q   <= 5'd0;
            src2_q   <= 5'd0;
            data1_q  <= 8'd0;
            data2_q  <= 8'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Queue storage; stale contents are unreachable once count is cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            qdst_q[wr_ptr_q] <= wb_dst;
            qdat_q[wr_ptr_q] <= wb_data;
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_regfile_access_ctrl;

    localparam int QD = 4;

    typedef struct packed {
        logic [4:0] dst;
        logic [7:0] data;
    } wb_t;

    logic       clk;
    logic       reset;
    logic       rd_req_valid;
    logic       rd_req_ready;
    logic [4:0] rd_src1;
    logic [4:0] rd_src2;
    logic       rd_rsp_valid;
    logic       rd_rsp_ready;
    logic [7:0] rd_data1;
    logic [7:0] rd_data2;
    logic       wb_valid;
    logic       wb_ready;
    logic [4:0] wb_dst;
    logic [7:0] wb_data;
    logic       rf_read;
    logic [4:0] rf_rsrc1;
    logic [4:0] rf_rsrc2;
    logic [4:0] rf_rdst;
    logic [7:0] rf_in;
    logic [7:0] rf_out1;
    logic [7:0] rf_out2;
    logic [3:0] wbq_count;

    int tests = 0;
    int fails = 0;

    logic [7:0] env_rf [32];
    logic [7:0] mrf [32];
    wb_t        mq [$];
    wb_t        wlog [$];
    int         stage;
    bit         mwriting;
    logic [4:0] ms1, ms2;
    logic [7:0] md1, md2;

    regfile_access_ctrl #(.QDEPTH(QD)) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_req_valid(rd_req_valid),
        .rd_req_ready(rd_req_ready),
        .rd_src1     (rd_src1),
        .rd_src2     (rd_src2),
        .rd_rsp_valid(rd_rsp_valid),
        .rd_rsp_ready(rd_rsp_ready),
        .rd_data1    (rd_data1),
        .rd_data2    (rd_data2),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_dst      (wb_dst),
        .wb_data     (wb_data),
        .rf_read     (rf_read),
        .rf_rsrc1    (rf_rsrc1),
        .rf_rsrc2    (rf_rsrc2),
        .rf_rdst     (rf_rdst),
        .rf_in       (rf_in),
        .rf_out1     (rf_out1),
        .rf_out2     (rf_out2),
        .wbq_count   (wbq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rf_out1 = env_rf[rf_rsrc1];
    assign rf_out2 = env_rf[rf_rsrc2];

    // Register file environment, driven only by the DUT's RF port.
    always @(posedge clk) begin
        if (rf_read === 1'b0) env_rf[rf_rdst] <= rf_in;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    function automatic logic [7:0] newest(input logic [4:0] r,
                                          input logic [7:0] dflt);
        logic [7:0] v;
        v = dflt;
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].dst == r) v = mq[i].data;
        return v;
    endfunction

    task automatic compare();
        bit idle;
        idle = !mwriting && stage == 0;
        chk("rf_read", rf_read, reset ? 1'b1 : !mwriting);
        chk("rf_rdst", rf_rdst,
            (!reset && mwriting) ? mq[0].dst : 5'd0);
        chk("rf_in", rf_in,
            (!reset && mwriting) ? mq[0].data : 8'd0);
        chk("rf_rsrc1", rf_rsrc1, (!reset && stage == 1) ? ms1 : 5'd0);
        chk("rf_rsrc2", rf_rsrc2, (!reset && stage == 1) ? ms2 : 5'd0);
        if (!reset) begin
            chk("wbq_count", wbq_count, mq.size());
            chk("wb_ready", wb_ready, mq.size() < QD);
            chk("rd_req_ready", rd_req_ready, idle && mq.size() < QD);
            chk("rd_rsp_valid", rd_rsp_valid, stage == 2);
            if (stage == 2) begin
                chk("rd_data1", rd_data1, md1);
                chk("rd_data2", rd_data2, md2);
            end
        end
    endtask

    task automatic model_step();
        bit idle, push, acc;
        int n;
        if (reset) begin
            mq.delete();
            stage    = 0;
            mwriting = 0;
            md1      = 8'd0;
            md2      = 8'd0;
            return;
        end
        n    = mq.size();
        idle = !mwriting && stage == 0;
        push = wb_valid && n < QD;
        acc  = idle && rd_req_valid && n < QD;
        if (stage == 1) begin
            md1 = (push && wb_dst == ms1) ? wb_data : newest(ms1, mrf[ms1]);
            md2 = (push && wb_dst == ms2) ? wb_data : newest(ms2, mrf[ms2]);
        end
        if (mwriting) begin
            mrf[mq[0].dst] = mq[0].data;
            void'(mq.pop_front());
            mwriting = 0;
        end else if (stage == 1) begin
            stage = 2;
        end else if (stage == 2) begin
            if (rd_rsp_ready) stage = 0;
        end else if (acc) begin
            stage = 1;
            ms1   = rd_src1;
            ms2   = rd_src2;
        end else if (n > 0) begin
            mwriting = 1;
        end
        if (push) mq.push_back({wb_dst, wb_data});
    endtask

    task automatic tick();
        #1;
        compare();
        if (!reset && rf_read === 1'b0) wlog.push_back({rf_rdst, rf_in});
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic quiesce();
        bit done;
        reset        = 1'b0;
        wb_valid     = 1'b0;
        rd_req_valid = 1'b0;
        rd_rsp_ready = 1'b1;
        done         = 0;
        for (int k = 0; k < 40; k++) begin
            if (stage == 0 && !mwriting && mq.size() == 0) begin
                done = 1;
                break;
            end
            tick();
        end
        chk("quiesce_timeout", done, 1'b1);
    endtask

    initial begin
        int         i;
        int         guard;
        bit         acc;
        for (int r = 0; r < 32; r++) begin
            env_rf[r] = 8'(r * 13);
            mrf[r]    = 8'(r * 13);
        end
        env_rf[3] = 8'd40;
        mrf[3]    = 8'd40;
        stage = 0; mwriting = 0; md1 = 0; md2 = 0; ms1 = 0; ms2 = 0;
        reset = 1'b1; rd_req_valid = 0; rd_src1 = 0; rd_src2 = 0;
        rd_rsp_ready = 0; wb_valid = 0; wb_dst = 0; wb_data = 0;
        @(negedge clk);
        tick();
        reset = 1'b0;
        settle();
        chk("rst_count", wbq_count, 4'd0);
        chk("rst_rsp_valid", rd_rsp_valid, 1'b0);
        chk("rst_data1", rd_data1, 8'd0);
        chk("rst_data2", rd_data2, 8'd0);
        chk("rst_rf_read", rf_read, 1'b1);
        chk("rst_rdst", rf_rdst, 5'd0);

        // write then read
        wlog.delete();
        wb_valid = 1; wb_dst = 5'd5; wb_data = 8'h2A;
        tick();
        wb_valid = 0;
        settle(); chk("s1_count", wbq_count, 4'd1);
        tick();
        settle();
        chk("s1_wr", rf_read, 1'b0);
        chk("s1_rdst", rf_rdst, 5'd5);
        chk("s1_in", rf_in, 8'h2A);
        tick();
        rd_req_valid = 1; rd_src1 = 5'd5; rd_src2 = 5'd3;
        settle(); chk("s1_req_ready", rd_req_ready, 1'b1);
        tick();
        rd_req_valid = 0;
        settle();
        chk("s1_rsrc1", rf_rsrc1, 5'd5);
        chk("s1_rsrc2", rf_rsrc2, 5'd3);
        chk("s1_early_valid", rd_rsp_valid, 1'b0);
        tick();
        rd_rsp_ready = 1;
        settle();
        chk("s1_valid", rd_rsp_valid, 1'b1);
        chk("s1_data1", rd_data1, 8'h2A);
        chk("s1_data2", rd_data2, 8'd40);
        tick();
        quiesce();
        chk("s1_nwrites", wlog.size(), 1);

        // bypass from youngest queued entry
        wlog.delete();
        wb_valid = 1; wb_dst = 5'd7; wb_data = 8'h11;
        tick();
        wb_data = 8'h22; rd_req_valid = 1; rd_src1 = 5'd7; rd_src2 = 5'd5;
        settle(); chk("s2_req_ready", rd_req_ready, 1'b1);
        tick();
        wb_valid = 0; rd_req_valid = 0;
        tick();
        rd_rsp_ready = 1;
        settle();
        chk("s2_data1", rd_data1, 8'h22);
        chk("s2_data2", rd_data2, 8'h2A);
        tick();
        quiesce();
        chk("s2_nwrites", wlog.size(), 2);
        if (wlog.size() >= 2) begin
            chk("s2_w0", wlog[0], {5'd7, 8'h11});
            chk("s2_w1", wlog[1], {5'd7, 8'h22});
        end
        chk("s2_rf7", env_rf[7], 8'h22);

        // full queue with a held read, plus response backpressure
        rd_rsp_ready = 0; rd_req_valid = 1; rd_src1 = 5'd1; rd_src2 = 5'd2;
        settle(); chk("s3_first_accept", rd_req_ready, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            wb_valid = 1; wb_dst = 5'(20 + k); wb_data = 8'(8'hA0 + k);
            if (k > 0) begin
                settle();
                chk("s3_valid", rd_rsp_valid, 1'b1);
                chk("s3_no_accept", rd_req_ready, 1'b0);
                chk("s3_hold1", rd_data1, 8'd13);
                chk("s3_hold2", rd_data2, 8'd26);
            end
            tick();
        end
        wb_valid = 0;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("s3_valid", rd_rsp_valid, 1'b1);
            chk("s3_hold1", rd_data1, 8'd13);
            chk("s3_full_count", wbq_count, 4'd4);
            chk("s3_wb_ready", wb_ready, 1'b0);
            tick();
        end
        rd_rsp_ready = 1;
        tick();
        rd_rsp_ready = 0;
        settle();
        chk("s3_full_req", rd_req_ready, 1'b0);
        chk("s3_full_wb", wb_ready, 1'b0);
        tick();
        settle();
        chk("s3_drain", rf_read, 1'b0);
        chk("s3_drain_dst", rf_rdst, 5'd20);
        chk("s3_drain_in", rf_in, 8'hA0);
        tick();
        settle();
        chk("s3_accept", rd_req_ready, 1'b1);
        chk("s3_accept_count", wbq_count, 4'd3);
        tick();
        rd_req_valid = 0;
        tick();
        rd_rsp_ready = 1;
        tick();
        quiesce();

        // reset mid-RESP with two entries queued
        rd_rsp_ready = 0; rd_req_valid = 1; rd_src1 = 5'd4; rd_src2 = 5'd6;
        tick();
        rd_req_valid = 0; wb_valid = 1; wb_dst = 5'd9; wb_data = 8'h99;
        tick();
        wb_dst = 5'd10; wb_data = 8'h9A;
        tick();
        wb_valid = 0; reset = 1;
        settle();
        chk("s4_count_pre", wbq_count, 4'd2);
        chk("s4_rst_rf_read", rf_read, 1'b1);
        tick();
        reset = 0;
        settle();
        chk("s4_rsp_valid", rd_rsp_valid, 1'b0);
        chk("s4_count", wbq_count, 4'd0);
        chk("s4_rf_read", rf_read, 1'b1);
        chk("s4_rf9", env_rf[9], 8'd117);
        tick();
        quiesce();

        // reset mid-WRITE drops the write
        wb_valid = 1; wb_dst = 5'd11; wb_data = 8'h55;
        tick();
        wb_valid = 0;
        tick();
        reset = 1;
        settle(); chk("s4w_rf_read", rf_read, 1'b1);
        tick();
        reset = 0;
        settle();
        chk("s4w_rf11", env_rf[11], 8'h8F);
        chk("s4w_count", wbq_count, 4'd0);
        tick();
        quiesce();

        // pointer wrap: ten writebacks in order
        wlog.delete();
        i = 1; guard = 0;
        while (i <= 10 && guard < 200) begin
            wb_valid = 1; wb_dst = 5'(i); wb_data = 8'(8'h80 + i);
            acc = mq.size() < QD;
            tick();
            if (acc) i++;
            guard++;
        end
        wb_valid = 0;
        quiesce();
        chk("s5_nwrites", wlog.size(), 10);
        for (int k = 0; k < 10 && k < wlog.size(); k++)
            chk("s5_order", wlog[k], {5'(k + 1), 8'(8'h81 + k)});
        chk("s5_rf10", env_rf[10], 8'h8A);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom_range(0, 149) == 0);
            rd_req_valid = $urandom_range(0, 1) == 1;
            rd_src1      = 5'($urandom_range(0, 7));
            rd_src2      = ($urandom_range(0, 3) == 0) ?
                           5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            wb_valid     = $urandom_range(0, 4) < 2;
            wb_dst       = 5'($urandom_range(0, 7));
            wb_data      = 8'($urandom_range(0, 255));
            rd_rsp_ready = $urandom_range(0, 1) == 1;
            tick();
        end
        quiesce();
        for (int r = 0; r < 32; r++) chk("final_rf", env_rf[r], mrf[r]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
